// File: rtl/ucc_region_cfg_if.sv
// Peripheral bus bundle between the openMSP430 core and the region config block.
// Latency: n/a (wires only); per_dout is a combinational response to the request.
// Backpressure: none, the peripheral bus completes every access in one cycle.
interface ucc_region_cfg_if;
  logic [13:0] per_addr;
  logic [15:0] per_din;
  logic        per_en;
  logic [1:0]  per_we;
  logic [15:0] per_dout;

  modport master (output per_addr, per_din, per_en, per_we, input per_dout);
  modport slave  (input per_addr, per_din, per_en, per_we, output per_dout);
endinterface

// File: rtl/ucc_region_cfg.sv
// UCC region-bounds register file: staging regs, validated commit to active bounds, sticky lock.
// Latency: reads combinational; a clean commit updates active outputs NUM_UCC+2 edges after the write.
// Backpressure: none on the bus; config writes are dropped while busy or locked.
module ucc_region_cfg #(
  parameter int          NUM_UCC   = 8,
  parameter logic [13:0] BASE_ADDR = 14'h0C0,
  parameter int          IDX_W     = 4
) (
  input  logic                   mclk,
  input  logic                   puc_rst_n,
  ucc_region_cfg_if.slave        per,
  output logic [16*NUM_UCC-1:0]  ucc_min,
  output logic [16*NUM_UCC-1:0]  ucc_max,
  output logic [NUM_UCC-1:0]     ucc_en,
  output logic                   cfg_locked,
  output logic                   cfg_busy
);

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_APPLY} state_t;

  localparam logic [13:0]      OFF_EN   = 14'(2*NUM_UCC);
  localparam logic [13:0]      OFF_CTRL = 14'(2*NUM_UCC + 1);
  localparam logic [13:0]      OFF_STAT = 14'(2*NUM_UCC + 2);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_UCC - 1);

  logic [15:0]        stg_min [NUM_UCC];
  logic [15:0]        stg_max [NUM_UCC];
  logic [NUM_UCC-1:0] enmask;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               err_q, err_d;
  logic [IDX_W-1:0]   err_idx_q, err_idx_d;
  logic               apply;
  logic               cur_fail;

  logic [13:0] off;
  logic        sel, rd, wr, cfg_open, commit_req, lock_req;
  logic [15:0] en_merged;
  logic [15:0] status_w;
  logic [15:0] rdata;

  function automatic logic [15:0] byte_merge(input logic [15:0] old_v,
                                             input logic [15:0] new_v,
                                             input logic [1:0]  we);
    return {we[1] ? new_v[15:8] : old_v[15:8], we[0] ? new_v[7:0] : old_v[7:0]};
  endfunction

  // Addresses below the base wrap to large offsets, so the lower bound check is explicit.
  assign off        = per.per_addr - BASE_ADDR;
  assign sel        = per.per_en && (per.per_addr >= BASE_ADDR) && (off <= OFF_STAT);
  assign rd         = sel && (per.per_we == 2'b00);
  assign wr         = sel && (per.per_we != 2'b00);
  assign cfg_open   = !cfg_locked && !cfg_busy;
  assign commit_req = wr && (off == OFF_CTRL) && per.per_we[0] && per.per_din[0] && cfg_open;
  assign lock_req   = wr && (off == OFF_CTRL) && per.per_we[0] && per.per_din[1];
  assign en_merged  = byte_merge(16'(enmask), per.per_din, per.per_we);
  assign cfg_busy   = (state_q != S_IDLE);

  // Staging registers and enable mask, frozen while a commit runs or after lock.
  always_ff @(posedge mclk or negedge puc_rst_n) begin
    if (!puc_rst_n) begin
      for (int i = 0; i < NUM_UCC; i++) begin
        stg_min[i] <= '0;
        stg_max[i] <= '0;
      end
      enmask <= '0;
    end else if (wr && cfg_open) begin
      for (int i = 0; i < NUM_UCC; i++) begin
        if (off == 14'(2*i))     stg_min[i] <= byte_merge(stg_min[i], per.per_din, per.per_we);
        if (off == 14'(2*i + 1)) stg_max[i] <= byte_merge(stg_max[i], per.per_din, per.per_we);
      end
      if (off == OFF_EN) enmask <= en_merged[NUM_UCC-1:0];
    end
  end

  // Sticky lock; honoured even mid-commit, only reset clears it.
  always_ff @(posedge mclk or negedge puc_rst_n) begin
    if (!puc_rst_n)    cfg_locked <= 1'b0;
    else if (lock_req) cfg_locked <= 1'b1;
  end

  // Validation verdict for the region currently under check.
  always_comb begin
    cur_fail = 1'b0;
    for (int i = 0; i < NUM_UCC; i++) begin
      if (idx_q == IDX_W'(i)) cur_fail = enmask[i] && (stg_min[i] > stg_max[i]);
    end
  end

  // Commit sequencer state register.
  always_ff @(posedge mclk or negedge puc_rst_n) begin
    if (!puc_rst_n) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      err_q     <= 1'b0;
      err_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      err_q     <= err_d;
      err_idx_q <= err_idx_d;
    end
  end

  // Commit sequencer: walk regions one per cycle, abort on first bad region, else apply.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    err_d     = err_q;
    err_idx_d = err_idx_q;
    apply     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (commit_req) begin
          state_d   = S_CHECK;
          idx_d     = '0;
          err_d     = 1'b0;
          err_idx_d = '0;
        end
      end
      S_CHECK: begin
        if (cur_fail) begin
          err_d     = 1'b1;
          err_idx_d = idx_q;
          state_d   = S_IDLE;
        end else if (idx_q == LAST_IDX) begin
          state_d = S_APPLY;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_APPLY: begin
        apply   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Active bounds swap atomically so the monitor never sees a half-applied set.
  always_ff @(posedge mclk or negedge puc_rst_n) begin
    if (!puc_rst_n) begin
      ucc_min <= '0;
      ucc_max <= '0;
      ucc_en  <= '0;
    end else if (apply) begin
      for (int i = 0; i < NUM_UCC; i++) begin
        ucc_min[16*i +: 16] <= stg_min[i];
        ucc_max[16*i +: 16] <= stg_max[i];
      end
      ucc_en <= enmask;
    end
  end

  // Combinational read mux; CTRL and unmapped offsets read as zero.
  always_comb begin
    status_w               = '0;
    status_w[0]            = cfg_busy;
    status_w[1]            = err_q;
    status_w[2]            = cfg_locked;
    status_w[8 +: IDX_W]   = err_idx_q;
    rdata = '0;
    if (rd) begin
      for (int i = 0; i < NUM_UCC; i++) begin
        if (off == 14'(2*i))     rdata = stg_min[i];
        if (off == 14'(2*i + 1)) rdata = stg_max[i];
      end
      if (off == OFF_EN)   rdata = 16'(enmask);
      if (off == OFF_STAT) rdata = status_w;
    end
  end

  assign per.per_dout = rdata;

endmodule
